// File: rtl/div_16_seq_pkg.sv
// Shared ALU definitions for the sequential divider: width, FSM encoding and
// the operand values that need special handling.
package alu_pkg;
  localparam int DIV_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam logic [DIV_W-1:0] INT_MIN = 16'h8000;
  localparam logic [DIV_W-1:0] NEG_ONE = 16'hFFFF;
endpackage

// File: rtl/div_16_seq_if.sv
// Start/result handshake between the ALU controller (master) and the
// sequential divider (slave).
interface div_16_seq_if import alu_pkg::*; ();
  logic             ctrl_DIV;
  logic [DIV_W-1:0] data_operandA;
  logic [DIV_W-1:0] data_operandB;
  logic [DIV_W-1:0] data_result;
  logic [DIV_W-1:0] data_remainder;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_remainder, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_remainder, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_16_seq_sub_rca_17.sv
// 17-bit ripple-carry subtractor computing a - b as a + ~b + 1.
module sub_rca_17 (
  input  logic [16:0] a_i,
  input  logic [16:0] b_i,
  output logic [16:0] diff_o,
  output logic        borrow_o
);
  logic [17:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 17; i++) begin : g_bit
    logic p;
    assign p            = a_i[i] ^ ~b_i[i];
    assign diff_o[i]    = p ^ carry[i];
    assign carry[i+1]   = (a_i[i] & ~b_i[i]) | (carry[i] & p);
  end

  // No carry out of the top bit means a < b.
  assign borrow_o = ~carry[17];
endmodule

// File: rtl/div_16_seq.sv
// Sequential 16-bit signed restoring divider: magnitudes are divided one
// quotient bit per cycle, then signs are applied in a final fix-up cycle.
module div_16_seq import alu_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  div_16_seq_if.slave bus
);
  div_state_e       state_q;
  logic [4:0]       cnt_q;
  logic [16:0]      r_q;
  logic [DIV_W-1:0] q_q;
  logic [DIV_W-1:0] b_q;
  logic             sa_q;
  logic             sb_q;
  logic [DIV_W-1:0] result_q;
  logic [DIV_W-1:0] rem_q;
  logic             exc_q;
  logic             rdy_q;
  logic             busy_q;

  // The two negators take the operands at start and the Q/R magnitudes in FIX.
  logic [DIV_W-1:0] neg_x_in, neg_y_in;
  logic [16:0]      neg_x_diff, neg_y_diff;
  logic             neg_x_borrow, neg_y_borrow;

  assign neg_x_in = (state_q == FIX) ? q_q       : bus.data_operandA;
  assign neg_y_in = (state_q == FIX) ? r_q[15:0] : bus.data_operandB;

  sub_rca_17 u_neg_x (
    .a_i      (17'd0),
    .b_i      ({1'b0, neg_x_in}),
    .diff_o   (neg_x_diff),
    .borrow_o (neg_x_borrow)
  );

  sub_rca_17 u_neg_y (
    .a_i      (17'd0),
    .b_i      ({1'b0, neg_y_in}),
    .diff_o   (neg_y_diff),
    .borrow_o (neg_y_borrow)
  );

  logic             sa_d, sb_d;
  logic [DIV_W-1:0] mag_a_d, mag_b_d;
  logic             div_zero, div_ovf;

  assign sa_d     = bus.data_operandA[DIV_W-1];
  assign sb_d     = bus.data_operandB[DIV_W-1];
  assign mag_a_d  = sa_d ? neg_x_diff[15:0] : bus.data_operandA;
  assign mag_b_d  = sb_d ? neg_y_diff[15:0] : bus.data_operandB;
  assign div_zero = (bus.data_operandB == '0);
  assign div_ovf  = (bus.data_operandA == INT_MIN) && (bus.data_operandB == NEG_ONE);

  logic [16:0]      trial_t;
  logic [16:0]      sub_diff;
  logic             sub_borrow;
  logic [16:0]      r_d;
  logic [DIV_W-1:0] q_d;

  assign trial_t = {r_q[15:0], q_q[DIV_W-1]};

  sub_rca_17 u_sub (
    .a_i      (trial_t),
    .b_i      ({1'b0, b_q}),
    .diff_o   (sub_diff),
    .borrow_o (sub_borrow)
  );

  // Restore the shifted partial remainder when the trial subtraction goes negative.
  assign r_d = sub_diff[16] ? trial_t : sub_diff;
  assign q_d = {q_q[DIV_W-2:0], ~sub_diff[16]};

  logic [DIV_W-1:0] quo_fix_d, rem_fix_d;

  assign quo_fix_d = (sa_q ^ sb_q) ? neg_x_diff[15:0] : q_q;
  assign rem_fix_d = sa_q          ? neg_y_diff[15:0] : r_q[15:0];

  logic unused_bits;
  assign unused_bits = ^{neg_x_diff[16], neg_x_borrow, neg_y_diff[16], neg_y_borrow,
                         sub_borrow, r_q[16]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      result_q <= '0;
      rem_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          rdy_q <= 1'b0;
          if (bus.ctrl_DIV) begin
            if (div_zero) begin
              result_q <= '0;
              rem_q    <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
              state_q  <= DONE;
            end else if (div_ovf) begin
              result_q <= INT_MIN;
              rem_q    <= '0;
              exc_q    <= 1'b1;
              rdy_q    <= 1'b1;
              state_q  <= DONE;
            end else begin
              sa_q    <= sa_d;
              sb_q    <= sb_d;
              b_q     <= mag_b_d;
              q_q     <= mag_a_d;
              r_q     <= '0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd15) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          result_q <= quo_fix_d;
          rem_q    <= rem_fix_d;
          exc_q    <= 1'b0;
          rdy_q    <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_remainder = rem_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;
endmodule

// File: tb/tb_div_16_seq.sv
// Scoreboard bench for div_16_seq: stimulus pushes expected results, a monitor
// pops and compares on every result-ready pulse.
module tb_div_16_seq;
  logic clock = 1'b0;
  logic reset = 1'b0;

  div_16_seq_if bus ();

  div_16_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] res;
    logic [15:0] rem;
    logic        exc;
    int          start;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always begin
    @(posedge clock);
    #1;
    if (bus.data_resultRDY === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdy actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result",    {16'd0, bus.data_result},    {16'd0, e.res});
        chk("remainder", {16'd0, bus.data_remainder}, {16'd0, e.rem});
        chk("exception", {31'd0, bus.data_exception}, {31'd0, e.exc});
        chk("rdy_latency", cyc - e.start, e.lat);
      end
    end
  end

  task automatic start_div(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input logic [15:0] rem,
                           input logic exc);
    exp_t e;
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    e.res = res; e.rem = rem; e.exc = exc; e.start = cyc + 1; e.lat = exc ? 0 : 17;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    chk("busy_after_start", {31'd0, bus.busy}, {31'd0, ~exc});
    @(negedge clock);
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = 16'($urandom);
    bus.data_operandB = 16'($urandom);
  endtask

  task automatic wait_rdy(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.data_resultRDY === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input logic [15:0] rem,
                         input logic exc);
    start_div(a, b, res, rem, exc);
    wait_rdy("rdy_seen");
    @(negedge clock);
    chk("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    exp_t e;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_result",    {16'd0, bus.data_result},    32'd0);
    chk("rst_remainder", {16'd0, bus.data_remainder}, 32'd0);
    chk("rst_exception", {31'd0, bus.data_exception}, 32'd0);
    chk("rst_rdy",       {31'd0, bus.data_resultRDY}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},           32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_div(16'd100,   16'd7,     16'h000E, 16'h0002, 1'b0);
    run_div(16'hFF9C,  16'd7,     16'hFFF2, 16'hFFFE, 1'b0);
    run_div(16'd100,   16'hFFF9,  16'hFFF2, 16'h0002, 1'b0);
    run_div(16'hFF9C,  16'hFFF9,  16'h000E, 16'hFFFE, 1'b0);
    run_div(16'd5,     16'd0,     16'h0000, 16'h0000, 1'b1);
    run_div(16'h8000,  16'hFFFF,  16'h8000, 16'h0000, 1'b1);
    run_div(16'h8000,  16'd1,     16'h8000, 16'h0000, 1'b0);
    run_div(16'h8000,  16'h8000,  16'h0001, 16'h0000, 1'b0);
    run_div(16'hFFFF,  16'h8000,  16'h0000, 16'hFFFF, 1'b0);
    run_div(16'd0,     16'd5,     16'h0000, 16'h0000, 1'b0);

    // Reset in the middle of a division discards it silently.
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 16'd100;
    bus.data_operandB = 16'd7;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    repeat (6) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("midrst_result",    {16'd0, bus.data_result},    32'd0);
    chk("midrst_remainder", {16'd0, bus.data_remainder}, 32'd0);
    chk("midrst_exception", {31'd0, bus.data_exception}, 32'd0);
    chk("midrst_busy",      {31'd0, bus.busy},           32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.data_resultRDY === 1'b1) n++;
    end
    chk("rdy_after_reset", n, 0);
    run_div(16'h7FFF, 16'h0003, 16'h2AAA, 16'h0001, 1'b0);

    // Start ignored during RUN, then back-to-back start in the DONE cycle.
    start_div(16'd9, 16'd2, 16'h0004, 16'h0001, 1'b0);
    repeat (4) @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 16'd50;
    bus.data_operandB = 16'd3;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    wait_rdy("rdy_first");
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = 16'd1000;
    bus.data_operandB = 16'hFFF6;
    e.res = 16'hFF9C; e.rem = 16'h0000; e.exc = 1'b0; e.start = cyc + 1; e.lat = 17;
    sb_q.push_back(e);
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    chk("busy_b2b", {31'd0, bus.busy}, 32'd1);
    wait_rdy("rdy_second");
    @(negedge clock);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clock);
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_16_seq.md
# div_16_seq

Sequential 16-bit signed divider for the ALU's multi-cycle datapath. It computes quotient and remainder of two's-complement operands by restoring division, one quotient bit per cycle, using a ripple-carry subtractor. It sits beside the combinational adder path and handshakes with the ALU controller through a start pulse and a one-cycle result-ready pulse.

## Interface
- WIDTH, 16, operand/result width; only 16 is verified
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- ctrl_DIV  in  1  start pulse; sampled only in IDLE or DONE
- data_operandA  in  16  dividend, two's complement; captured on the start edge
- data_operandB  in  16  divisor, two's complement; captured on the start edge
- data_result  out  16  quotient, registered; holds until the next result
- data_remainder  out  16  remainder, registered; holds until the next result
- data_exception  out  1  divide-by-zero or overflow; valid with data_resultRDY and held afterwards
- data_resultRDY  out  1  one-cycle pulse when the outputs are updated
- busy  out  1  high in RUN and FIX

## Operation
- States: IDLE, RUN, FIX, DONE. Reset value is IDLE.
- IDLE/DONE with ctrl_DIV=1:
  - Capture |A|, |B| and the signs sA, sB.
  - Clear R (17-bit) and the counter; Q = |A|.
  - Go to RUN.
  - Exception check on the same edge:
    - B==0: go to DONE with result=0, remainder=0, exception=1.
    - A==0x8000 and B==0xFFFF: go to DONE with result=0x8000, remainder=0, exception=1.
- RUN, one iteration per edge:
  - T = {R[15:0], Q[15]}; diff = T − {0,|B|} using the 17-bit subtractor.
  - If diff[16]==0: R=diff, Q={Q[14:0],1}. Otherwise: R=T, Q={Q[14:0],0}.
  - Counter increments. After the 16th iteration, go to FIX.
- FIX:
  - Quotient = Q, negated if sA≠sB.
  - Remainder = R[15:0], negated if sA=1.
  - Register both, exception=0, go to DONE.
- DONE:
  - data_resultRDY=1 for exactly this cycle.
  - Next state is IDLE, or RUN (or the exception path) if ctrl_DIV=1.
- ctrl_DIV in RUN or FIX is ignored; no queueing.
- Rounding: quotient truncates toward zero. Remainder takes the sign of the dividend. |remainder| < |divisor|.
- |A| for 0x8000 is 0x8000 treated as unsigned 16-bit; the magnitude path is unsigned.
- Reset values: data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0, busy=0.

## Timing
- Start edge k (ctrl_DIV high in IDLE/DONE).
- Normal path:
  - RUN iterations on edges k+1..k+16.
  - FIX registers the outputs on edge k+17.
  - data_resultRDY is high during cycle k+17→k+18, i.e. 17 cycles after the start edge.
- Exception path: outputs are registered on edge k. data_resultRDY is high during cycle k→k+1.
- busy is high from edge k to edge k+17 on the normal path. It never rises on the exception path.
- Back-to-back: ctrl_DIV high in DONE starts the next division on that edge; the RDY pulse still lasts exactly one cycle.
- Asynchronous reset mid-operation:
  - Forces IDLE immediately and clears all outputs.
  - The in-flight result is discarded.
  - No RDY pulse is produced after reset deasserts.
- Operand inputs are don't-care except on the start edge.

## Structure
- Shared package alu_pkg holds:
  - DIV_W=16
  - the state encoding (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3)
  - the constants INT_MIN=16'h8000 and NEG_ONE=16'hFFFF
- One sub-module, sub_rca_17: 17-bit ripple-carry subtractor (a + ~b + 1), outputs diff and borrow. It is reused for magnitude/negation via a 0 − x instance, or by inline two's-complement logic.
- The FSM, counter (5-bit) and the R/Q registers live in div_16_seq.

## Test plan
- A=100 (0x0064), B=7: RDY 17 cycles after start; result=0x000E, remainder=0x0002, exception=0.
- A=−100 (0xFF9C), B=7: result=0xFFF2 (−14), remainder=0xFFFE (−2). A=100, B=−7: result=0xFFF2, remainder=0x0002.
- A=5, B=0: RDY one cycle after start; exception=1, result=0, remainder=0; busy never high.
- A=0x8000, B=0xFFFF: exception=1, result=0x8000, remainder=0. A=0x8000, B=1: result=0x8000, remainder=0, exception=0.
- Start 100/7; assert reset at cycle 8 for 2 cycles: all outputs 0, no RDY pulse for 20 cycles. Then 0x7FFF/0x0003 gives result=0x2AAA, remainder=0x0001.
- Start 9/2. Pulse ctrl_DIV during RUN: ignored. In the DONE cycle start 1000/−10: first RDY gives 4 r 1; second RDY 17 cycles later gives 0xFF9C r 0.
